// File: rtl/nes_joypad_ctrl.sv
// NES controller-port engine: synchronises, debounces and autofire-gates raw button
// vectors, serves them serially per $4016/$4017, and raises a per-player change IRQ.
module nes_joypad_ctrl #(
  parameter int C_players       = 2,
  parameter int C_buttons       = 8,
  parameter int C_debounce_bits = 20,
  parameter int C_clk_hz        = 21477272,
  parameter int C_autofire_hz   = 10,
  parameter bit C_serial_fill   = 1'b1
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic [C_players*C_buttons-1:0] i_btn,
  input  logic [C_players*C_buttons-1:0] i_autofire_en,
  input  logic                           i_strobe,
  input  logic [C_players-1:0]           i_joy_clock,
  output logic [C_players-1:0]           o_data,
  output logic [C_players*C_buttons-1:0] o_state,
  output logic                           o_irq,
  input  logic                           i_irq_ack,
  output logic [C_players-1:0]           o_changed
);

  localparam int NB    = C_players * C_buttons;
  localparam int HALF  = C_clk_hz / (2 * C_autofire_hz);
  localparam int PRE_W = (HALF > 1) ? $clog2(HALF) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'((HALF > 1) ? HALF - 1 : 0);

  logic [NB-1:0]              btn_p0, btn_p1, af_p0, af_p1;
  logic [C_debounce_bits-1:0] cnt [C_players];
  logic [NB-1:0]              state;
  logic [C_players-1:0]       change;
  logic [PRE_W-1:0]           pre;
  logic                       phase;
  logic [NB-1:0]              eff;
  logic [C_buttons-1:0]       sr [C_players];
  logic [C_players-1:0]       jc_prev;
  logic                       irq;
  logic [C_players-1:0]       changed;

  function automatic logic [C_debounce_bits-1:0] sat_inc(input logic [C_debounce_bits-1:0] c);
    return c[C_debounce_bits-1] ? c : c + C_debounce_bits'(1);
  endfunction

  // Stage p0/p1: two-flop synchroniser for the asynchronous button and autofire inputs
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      btn_p0 <= '0;
      btn_p1 <= '0;
      af_p0  <= '0;
      af_p1  <= '0;
    end else begin
      btn_p0 <= i_btn;
      btn_p1 <= btn_p0;
      af_p0  <= i_autofire_en;
      af_p1  <= af_p0;
    end
  end

  // Debounce: the counter enforces a minimum interval between accepted vector changes
  always_comb begin
    change = '0;
    for (int p = 0; p < C_players; p++)
      change[p] = (btn_p1[p*C_buttons +: C_buttons] != state[p*C_buttons +: C_buttons])
                  && cnt[p][C_debounce_bits-1];
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= '0;
      for (int p = 0; p < C_players; p++) cnt[p] <= '0;
    end else begin
      for (int p = 0; p < C_players; p++) begin
        if (change[p]) begin
          state[p*C_buttons +: C_buttons] <= btn_p1[p*C_buttons +: C_buttons];
          cnt[p] <= '0;
        end else begin
          cnt[p] <= sat_inc(cnt[p]);
        end
      end
    end
  end

  // Autofire phase generator; gating applies only to what the NES sees, never to state
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pre   <= '0;
      phase <= 1'b0;
    end else if (pre == PRE_LAST) begin
      pre   <= '0;
      phase <= ~phase;
    end else begin
      pre <= pre + PRE_W'(1);
    end
  end

  always_comb begin
    eff = '0;
    for (int p = 0; p < C_players; p++)
      eff[p*C_buttons +: C_buttons] = state[p*C_buttons +: C_buttons]
        & (~af_p1[p*C_buttons +: C_buttons] | {C_buttons{phase}});
  end

  // Serial shifters: strobe load has priority over a coincident joy-clock falling edge
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      jc_prev <= '0;
      for (int p = 0; p < C_players; p++) sr[p] <= '0;
    end else begin
      jc_prev <= i_joy_clock;
      for (int p = 0; p < C_players; p++) begin
        if (i_strobe)
          sr[p] <= eff[p*C_buttons +: C_buttons];
        else if (jc_prev[p] && !i_joy_clock[p])
          sr[p] <= {C_serial_fill, sr[p][C_buttons-1:1]};
      end
    end
  end

  always_comb begin
    o_data = '0;
    for (int p = 0; p < C_players; p++) o_data[p] = sr[p][0];
  end

  // Change IRQ: a change landing with the ack survives it
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      irq     <= 1'b0;
      changed <= '0;
    end else if (i_irq_ack) begin
      irq     <= |change;
      changed <= change;
    end else begin
      irq     <= irq | (|change);
      changed <= changed | change;
    end
  end

  assign o_state   = state;
  assign o_irq     = irq;
  assign o_changed = changed;

endmodule

// File: tb/tb_nes_joypad_ctrl.sv
// Bench for nes_joypad_ctrl: directed scenarios plus random traffic, every cycle compared
// against a behavioural model (history arrays, settle ages, read indices into a loaded vector).
module tb_nes_joypad_ctrl;
  localparam int P = 2;
  localparam int B = 8;
  localparam int DB = 4;
  localparam int HZ = 100;
  localparam int AF = 5;
  localparam int HALF = HZ / (2 * AF);
  localparam int SETTLE = 2 ** (DB - 1);
  localparam bit FILL = 1'b1;

  logic             clock = 1'b0;
  logic             reset = 1'b1;
  logic [P*B-1:0]   i_btn = '0;
  logic [P*B-1:0]   i_autofire_en = '0;
  logic             i_strobe = 1'b0;
  logic [P-1:0]     i_joy_clock = '0;
  logic [P-1:0]     o_data;
  logic [P*B-1:0]   o_state;
  logic             o_irq;
  logic             i_irq_ack = 1'b0;
  logic [P-1:0]     o_changed;

  int n_assert = 0;
  int n_fail = 0;

  nes_joypad_ctrl #(
    .C_players(P), .C_buttons(B), .C_debounce_bits(DB),
    .C_clk_hz(HZ), .C_autofire_hz(AF), .C_serial_fill(FILL)
  ) dut (
    .clock(clock), .reset(reset), .i_btn(i_btn), .i_autofire_en(i_autofire_en),
    .i_strobe(i_strobe), .i_joy_clock(i_joy_clock), .o_data(o_data), .o_state(o_state),
    .o_irq(o_irq), .i_irq_ack(i_irq_ack), .o_changed(o_changed)
  );

  always #5 clock = ~clock;

  // Reference model
  logic [P*B-1:0] h1 = '0, h2 = '0, a1 = '0, a2 = '0;
  logic [P*B-1:0] m_state = '0;
  int             age [P];
  int             n_edges = 0;
  logic [B-1:0]   ld [P];
  int             rd [P];
  logic [P-1:0]   m_prev = '0;
  logic [P-1:0]   m_changed = '0;
  logic           m_irq = 1'b0;

  always @(posedge clock or posedge reset) begin
    logic           ph;
    logic [P*B-1:0] effv;
    logic [P-1:0]   chg;
    if (reset) begin
      h1 = '0; h2 = '0; a1 = '0; a2 = '0; m_state = '0; n_edges = 0;
      m_prev = '0; m_changed = '0; m_irq = 1'b0;
      for (int p = 0; p < P; p++) begin age[p] = 0; ld[p] = '0; rd[p] = 0; end
    end else begin
      ph = ((n_edges / HALF) % 2) == 1;
      for (int i = 0; i < P*B; i++) effv[i] = m_state[i] && (!a2[i] || ph);
      for (int p = 0; p < P; p++) begin
        if (i_strobe) begin
          ld[p] = effv[p*B +: B];
          rd[p] = 0;
        end else if (m_prev[p] && !i_joy_clock[p] && rd[p] < 1000) begin
          rd[p] = rd[p] + 1;
        end
      end
      m_prev = i_joy_clock;
      chg = '0;
      for (int p = 0; p < P; p++) begin
        if (h2[p*B +: B] != m_state[p*B +: B] && age[p] >= SETTLE) begin
          m_state[p*B +: B] = h2[p*B +: B];
          age[p] = 0;
          chg[p] = 1'b1;
        end else if (age[p] < SETTLE) begin
          age[p] = age[p] + 1;
        end
      end
      if (i_irq_ack) begin
        m_changed = chg;
        m_irq = |chg;
      end else begin
        m_changed = m_changed | chg;
        m_irq = m_irq | (|chg);
      end
      h2 = h1; h1 = i_btn; a2 = a1; a1 = i_autofire_en;
      n_edges = n_edges + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_model();
    logic [P-1:0] exp_d;
    for (int p = 0; p < P; p++) exp_d[p] = (rd[p] < B) ? ld[p][rd[p]] : FILL;
    chk("model_data", 32'(o_data), 32'(exp_d));
    chk("model_state", 32'(o_state), 32'(m_state));
    chk("model_irq", 32'(o_irq), 32'(m_irq));
    chk("model_changed", 32'(o_changed), 32'(m_changed));
  endtask

  task automatic step();
    @(posedge clock);
    @(negedge clock);
    check_model();
  endtask

  task automatic pulse0();
    i_joy_clock[0] = 1'b1;
    step();
    i_joy_clock[0] = 1'b0;
    step();
  endtask

  initial begin
    logic exp_seq [11];
    int   last_t, tcount;
    logic prev_d;
    exp_seq = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};

    repeat (3) step();
    chk("rst_data", 32'(o_data), 32'd0);
    chk("rst_state", 32'(o_state), 32'd0);
    chk("rst_irq", 32'(o_irq), 32'd0);
    chk("rst_changed", 32'(o_changed), 32'd0);
    reset = 1'b0;

    // Short glitch right after reset is not accepted; a sustained press is
    i_btn = 16'h0001;
    repeat (5) step();
    i_btn = 16'h0000;
    repeat (10) step();
    chk("glitch_state", 32'(o_state), 32'h0);
    chk("glitch_irq", 32'(o_irq), 32'd0);
    i_btn = 16'h0001;
    repeat (12) step();
    chk("press_state", 32'(o_state), 32'h0001);
    chk("press_irq", 32'(o_irq), 32'd1);
    chk("press_changed", 32'(o_changed), 32'b01);

    // Serial read of 8'b1000_0101 followed by fill bits
    i_btn = 16'h0085;
    repeat (14) step();
    chk("serial_state", 32'(o_state), 32'h0085);
    i_strobe = 1'b1;
    step(); step();
    i_strobe = 1'b0;
    step();
    chk("serial_bit0", 32'(o_data[0]), 32'(exp_seq[0]));
    for (int i = 1; i < 11; i++) begin
      pulse0();
      chk($sformatf("serial_bit%0d", i), 32'(o_data[0]), 32'(exp_seq[i]));
    end

    // Strobe held high: joy clocks ignored, A keeps being presented
    i_strobe = 1'b1;
    for (int i = 0; i < 4; i++) begin
      pulse0();
      chk("strobe_hold", 32'(o_data[0]), 32'd1);
    end

    // Autofire on A: presented value toggles every HALF clocks
    i_autofire_en = 16'h0001;
    repeat (3) step();
    last_t = -1;
    tcount = 0;
    prev_d = o_data[0];
    for (int i = 0; i < 45; i++) begin
      step();
      if (o_data[0] !== prev_d) begin
        if (last_t >= 0) chk("af_period", 32'(i - last_t), 32'(HALF));
        last_t = i;
        tcount++;
        prev_d = o_data[0];
      end
    end
    chk("af_toggles", 32'(tcount >= 3), 32'd1);
    i_autofire_en = 16'h0000;
    repeat (4) step();
    for (int i = 0; i < 20; i++) begin
      step();
      chk("af_off", 32'(o_data[0]), 32'd1);
    end
    i_strobe = 1'b0;

    // Ack clears, then ack coinciding with a player-1 change keeps the IRQ
    i_irq_ack = 1'b1;
    step();
    i_irq_ack = 1'b0;
    chk("ack_irq", 32'(o_irq), 32'd0);
    chk("ack_changed", 32'(o_changed), 32'd0);
    i_btn = 16'h0185;
    step(); step();
    i_irq_ack = 1'b1;
    step();
    i_irq_ack = 1'b0;
    chk("race_irq", 32'(o_irq), 32'd1);
    chk("race_changed", 32'(o_changed), 32'b10);

    // Asynchronous reset in the middle of a read
    i_strobe = 1'b1;
    step();
    i_strobe = 1'b0;
    step();
    repeat (3) pulse0();
    #2 reset = 1'b1;
    #1;
    chk("areset_data", 32'(o_data), 32'd0);
    chk("areset_state", 32'(o_state), 32'd0);
    chk("areset_irq", 32'(o_irq), 32'd0);
    chk("areset_changed", 32'(o_changed), 32'd0);
    step(); step();
    reset = 1'b0;
    repeat (14) step();
    i_strobe = 1'b1;
    step();
    i_strobe = 1'b0;
    step();
    chk("restart_bitA", 32'(o_data[0]), 32'd1);
    pulse0();
    chk("restart_bitB", 32'(o_data[0]), 32'd0);

    // Random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 19) == 0) i_btn = 16'($urandom);
      if ($urandom_range(0, 49) == 0) i_autofire_en = 16'($urandom);
      i_strobe = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 2) == 0) i_joy_clock = 2'($urandom);
      i_irq_ack = ($urandom_range(0, 29) == 0);
      step();
    end
    i_irq_ack = 1'b0;
    i_strobe = 1'b0;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
